// File: rtl/piso_tx.sv
// piso_tx: parallel-in, serial-out transmitter for the 4-bit serial shift link.
// Accepts a WIDTH-bit word over valid/ready and shifts it out MSB first, one bit
// per clock, with back-to-back words streamed without an idle gap.
// Optional feature macro: PISO_TX_PARITY_EN appends one even-parity bit per frame.
//
// Handshake: a word transfers on the rising edge where load_valid=1 and
// load_ready=1. data_in is sampled only at that edge. load_ready depends only on
// state_q/cnt_q (never on load_valid) and is high in IDLE and in the final frame
// bit cycle, so a waiting producer is held off without dropping or duplicating.
module piso_tx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  // state_q is the observable FSM state for checkers bound to this block.
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_data_bit;
  logic               accept;

`ifdef PISO_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  assign last_data_bit = (state_q == ST_SHIFT) && (cnt_q == '0);
  assign accept        = load_valid && load_ready;

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PISO_TX_PARITY_EN
  // Parity of the captured word, registered at the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  // Next-state logic: a transfer in the final bit cycle chains straight into SHIFT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
`ifdef PISO_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = accept ? ST_SHIFT : ST_IDLE;
`endif
        end
      end
`ifdef PISO_TX_PARITY_EN
      ST_PARITY: begin
        state_d = accept ? ST_SHIFT : ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: load on transfer, otherwise shift left while in SHIFT; the counter
  // holds at zero rather than wrapping.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
`ifdef PISO_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (accept) begin
      shift_d = data_in;
      cnt_d   = CNT_W'(WIDTH - 1);
`ifdef PISO_TX_PARITY_EN
      parity_d = ^data_in;
`endif
    end else if (state_q == ST_SHIFT) begin
      shift_d = {shift_q[WIDTH-2:0], 1'b0};
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  // Outputs decoded from state only; sout is forced low outside a frame.
  always_comb begin
    sout       = 1'b0;
    sout_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    load_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_ready = 1'b1;
      end
      ST_SHIFT: begin
        sout       = shift_q[WIDTH-1];
        sout_valid = 1'b1;
        busy       = 1'b1;
`ifndef PISO_TX_PARITY_EN
        done       = last_data_bit;
        load_ready = last_data_bit;
`endif
      end
`ifdef PISO_TX_PARITY_EN
      ST_PARITY: begin
        sout       = parity_q;
        sout_valid = 1'b1;
        busy       = 1'b1;
        done       = 1'b1;
        load_ready = 1'b1;
      end
`endif
      default: begin
        load_ready = 1'b0;
      end
    endcase
  end

`ifdef PISO_TX_PARITY_EN
  // In the parity build the last data bit is an ordinary SHIFT cycle.
  logic unused_last;
  assign unused_last = last_data_bit;
`endif

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: self-checking bench for piso_tx.
// Expected serial bits (with their done flag) are queued when a word is accepted
// and compared as the DUT emits them.
module tb_piso_tx;

  localparam int W = 4;
`ifdef PISO_TX_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  // Clock and reset
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         load_valid = 1'b0;
  logic         load_ready, sout, sout_valid, busy, done;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done)
  );

  // Scoreboard: each entry is {expected sout, expected done}
  logic [1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int valid_cycles = 0;
  int valid_runs = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (sout_valid) begin
        valid_cycles++;
        if (!prev_valid) valid_runs++;
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_bit", 32'd1, 32'd0);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          check("sout_done", {30'd0, sout, done}, {30'd0, e});
        end
      end else begin
        check("idle_sout", {29'd0, sout, done, busy}, 32'd0);
      end
      prev_valid = sout_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Driver: present a word and wait (bounded) for it to be accepted.
  // Runs in the posedge+1 phase; pushes the expected frame at the accept edge.
  task automatic send_word(input logic [W-1:0] d, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    data_in = d;
    load_valid = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (load_ready) begin
        for (int b = W - 1; b >= 0; b--)
          exp_q.push_back({d[b], (FRAME == W && b == 0) ? 1'b1 : 1'b0});
        if (FRAME != W) exp_q.push_back({^d, 1'b1});
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      waits++;
      @(posedge clk); #1;
    end
    if (!ok) check("accept_timeout", 32'd1, 32'd0);
    data_in = $urandom_range(0, (1 << W) - 1);
  endtask

  task automatic idle_cycles(input int n);
    load_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    load_valid = 1'b0;
    for (int i = 0; i < 8 * FRAME; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      @(posedge clk); #1;
    end
    check("drain_empty", exp_q.size(), 32'd0);
    idle_cycles(2);
  endtask

  initial begin
    int waits;
    int runs0, cyc0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {27'd0, sout, sout_valid, busy, done, load_ready}, 32'd1);
    rst = 1'b0;

    // Idle stability
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, load_ready}, 32'd1);
    end
    @(posedge clk); #1;

    // Single word 1011
    runs0 = valid_runs; cyc0 = valid_cycles;
    send_word(4'b1011, waits);
    load_valid = 1'b0;
    check("single_wait", waits, 32'd0);
    check("first_bit_latency", {30'd0, sout_valid, sout}, 32'd3);
    drain();
    check("single_runs", valid_runs - runs0, 32'd1);
    check("single_len", valid_cycles - cyc0, FRAME);

    // Back-to-back A then 5
    runs0 = valid_runs; cyc0 = valid_cycles;
    send_word(4'hA, waits);
    send_word(4'h5, waits);
    check("b2b_wait", waits, FRAME - 1);
    drain();
    check("b2b_runs", valid_runs - runs0, 32'd1);
    check("b2b_len", valid_cycles - cyc0, 2 * FRAME);

    // Hold-off: 4'h3 presented during cycle 2 of the 4'hF frame
    runs0 = valid_runs; cyc0 = valid_cycles;
    send_word(4'hF, waits);
    load_valid = 1'b0;
    @(posedge clk); #1;
    check("holdoff_not_ready", {31'd0, load_ready}, 32'd0);
    send_word(4'h3, waits);
    load_valid = 1'b0;
    check("holdoff_wait", waits, FRAME - 2);
    drain();
    check("holdoff_runs", valid_runs - runs0, 32'd1);
    check("holdoff_len", valid_cycles - cyc0, 2 * FRAME);

    // Reset mid-frame on 1100
    send_word(4'b1100, waits);
    load_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_abort_outputs", {27'd0, sout, sout_valid, busy, done, load_ready}, 32'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    runs0 = valid_runs;
    idle_cycles(FRAME + 3);
    check("rst_no_stray", valid_runs - runs0, 32'd0);
    check("rst_ready", {31'd0, load_ready}, 32'd1);

    // Parity pattern 0111 (plain 4-bit frame when parity is off)
    runs0 = valid_runs; cyc0 = valid_cycles;
    send_word(4'b0111, waits);
    drain();
    check("p0111_len", valid_cycles - cyc0, FRAME);

    // Random words with random gaps
    for (int n = 0; n < 12; n++) begin
      send_word(W'($urandom_range(0, (1 << W) - 1)), waits);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, FRAME + 1));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in, serial-out transmitter. It is the sending end of the team's 4-bit serial shift link.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB first, one bit per clock.
- The companion shift-left receiver therefore reassembles the word in its original bit order.
- Sits between a word-producing datapath and the serial line. Supports back-to-back words with no idle gap.

Parameters:
- WIDTH, 4, data word width in bits. Legal range is WIDTH >= 2.
- CNT_W, $clog2(WIDTH), width of the internal bit counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  parallel word to transmit.
- load_valid  input  1  producer asserts when data_in holds a word.
- load_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data bit.
- sout_valid  output  1  high in every cycle sout carries a frame bit.
- busy  output  1  high while a frame is in progress (state != IDLE).
- done  output  1  high during the cycle the final frame bit is on sout.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, shift_reg=0, bit_cnt=0.
  - sout=0, sout_valid=0, busy=0, done=0, load_ready=1.
  - load_valid is ignored while rst=1.
  - Reset mid-frame aborts the frame immediately; no partial bits follow after rst deasserts.
- States: IDLE, SHIFT, plus PARITY when the optional feature is enabled.
- Handshake:
  - A transfer occurs on the rising edge where load_valid=1 and load_ready=1.
  - data_in is sampled only at that edge; the producer may change it afterwards.
  - load_ready=1 in IDLE.
  - load_ready=1 in the final-bit cycle (SHIFT with bit_cnt=0, or PARITY when enabled).
  - load_ready=0 otherwise.
  - load_ready is combinational from state/bit_cnt only, never from load_valid.
- IDLE:
  - sout=0, sout_valid=0.
  - On transfer: shift_reg<=data_in, bit_cnt<=WIDTH-1, go to SHIFT.
  - With no transfer, stay in IDLE.
- SHIFT:
  - sout=shift_reg[WIDTH-1], sout_valid=1.
  - Each edge: shift_reg<={shift_reg[WIDTH-2:0],1'b0}, bit_cnt<=bit_cnt-1.
  - When bit_cnt=0, this is the last data bit:
    - Without the feature, done=1 this cycle.
    - At the edge: a transfer reloads shift_reg and bit_cnt and stays in SHIFT (back-to-back). With no transfer, go to IDLE.
- Latency: the first bit (data_in[WIDTH-1]) appears on sout the cycle after the accepting edge.
- Frame length: sout_valid stays high for exactly WIDTH consecutive cycles per word (WIDTH+1 with parity). A continuous stream has no gaps.
- Simultaneous events:
  - A transfer in the final-bit cycle takes effect at the same edge the frame completes; done still pulses for the finishing frame.
  - load_valid held high with load_ready=0 is simply held off. The word is neither dropped nor duplicated.
- bit_cnt never wraps: it is reloaded or the FSM leaves SHIFT when bit_cnt=0.
- sout is 0 whenever sout_valid=0.

Optional Feature:
- Macro: PISO_TX_PARITY_EN.
- Defined:
  - After the LSB, the block spends one extra cycle in PARITY, driving sout = even parity (XOR reduction) of the captured word, with sout_valid=1.
  - The parity bit is computed and registered at the accepting edge.
  - done and load_ready move to the PARITY cycle; the SHIFT bit_cnt=0 cycle no longer asserts either.
  - PARITY exits to SHIFT on a transfer, otherwise to IDLE.
- Undefined: PARITY state and parity register are absent; frames are WIDTH bits.

Test Plan:
- Single word, WIDTH=4:
  - Stimulus: reset, then data_in=4'b1011 with load_valid for one cycle.
  - Required: sout=1,0,1,1 on cycles 1-4 after the accept edge; sout_valid=1 for those 4 cycles; done=1 only in cycle 4; then IDLE with sout=0.
- Back-to-back:
  - Stimulus: load_valid held high with 4'hA then 4'h5 (change data after each accept).
  - Required: sout=1,0,1,0,0,1,0,1 with sout_valid continuously 1 for 8 cycles; done pulses in cycles 4 and 8.
- Hold-off:
  - Stimulus: assert load_valid with 4'h3 during cycle 2 of the frame for 4'hF.
  - Required: load_ready=0 until cycle 4; 4'h3 is accepted at the end of cycle 4; output is 1111 then 0011 with no gap and no duplicate.
- Reset mid-frame:
  - Stimulus: assert rst asynchronously in cycle 2 of 4'b1100.
  - Required: sout, sout_valid, busy and done drop to 0 immediately; after release, IDLE with load_ready=1 and no stray bits.
- Parity (PISO_TX_PARITY_EN):
  - Stimulus: send 4'b0111.
  - Required: sout=0,1,1,1 then parity bit 1; sout_valid high for 5 cycles; done only in cycle 5.
- Idle stability:
  - Stimulus: load_valid=0 for 20 cycles after reset.
  - Required: sout=0, sout_valid=0, busy=0, done=0 and load_ready=1 throughout.
